// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM layer scheduler.
package cim_pkg;

  typedef enum logic [1:0] {
    L_IDLE,
    L_FETCH,
    L_FULL
  } t_sched_ld_state;

  typedef enum logic [2:0] {
    C_IDLE,
    C_WAIT_WIN,
    C_MVM,
    C_WAIT_FUNC,
    C_DRAIN
  } t_sched_cmp_state;

  // Ceiling log2, never less than 1 so a 1x1 map still gets a 1-bit coordinate.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/conv_layer_sched_raster_ctr.sv
// Raster-order (row, col) counter over a DIM x DIM map; wraps to (0,0) after the last pixel.
module raster_ctr
  import cim_pkg::*;
#(
  parameter int unsigned DIM = 6,
  parameter int unsigned CW  = clog2_min1(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last
);

  localparam logic [CW-1:0] MAX = CW'(DIM - 1);

  logic col_end;
  logic row_end;

  assign col_end = (o_col == MAX);
  assign row_end = (o_row == MAX);
  assign o_last  = col_end && row_end;

  // Advance column, wrap into next row, wrap to origin after the last pixel.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      o_row <= '0;
      o_col <= '0;
    end else if (i_inc) begin
      if (col_end) begin
        o_col <= '0;
        o_row <= row_end ? '0 : o_row + 1'b1;
      end else begin
        o_col <= o_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// Per-layer conv scheduler: raster-scans output pixels, running window load, CIM MVM and
// post-process per pixel, with the next window load overlapped on the current compute/drain.
module conv_layer_sched
  import cim_pkg::*;
#(
  parameter int unsigned IMG_DIM    = 8,
  parameter int unsigned KERNEL_DIM = 3,
  parameter int unsigned OUT_DIM    = IMG_DIM - KERNEL_DIM + 1,
  parameter int unsigned CW         = clog2_min1(OUT_DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  output logic          o_ready,
  output logic          o_done,
  output logic          o_win_start,
  output logic [CW-1:0] o_win_row,
  output logic [CW-1:0] o_win_col,
  input  logic          i_win_done,
  output logic          o_cim_start,
  input  logic          i_cim_done,
  output logic          o_func_start,
  input  logic          i_func_ready,
  input  logic          i_next_ready,
  input  logic          i_func_done,
  output logic [CW-1:0] o_out_row,
  output logic [CW-1:0] o_out_col
);

  t_sched_ld_state  ld_state, ld_next;
  t_sched_cmp_state cmp_state, cmp_next;

  logic ld_first;
  logic win_valid;
  logic start_accept;
  logic out_inc;
  logic ld_last;
  logic out_last;

  // A resident window is exactly the loader sitting in L_FULL.
  assign win_valid = (ld_state == L_FULL);

  raster_ctr #(
    .DIM (OUT_DIM),
    .CW  (CW)
  ) u_ld_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (start_accept),
    .i_inc  (o_cim_start),
    .o_row  (o_win_row),
    .o_col  (o_win_col),
    .o_last (ld_last)
  );

  raster_ctr #(
    .DIM (OUT_DIM),
    .CW  (CW)
  ) u_out_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (start_accept),
    .i_inc  (out_inc),
    .o_row  (o_out_row),
    .o_col  (o_out_col),
    .o_last (out_last)
  );

  // State registers for both FSMs; ld_first marks the first cycle spent in L_FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state  <= L_IDLE;
      cmp_state <= C_IDLE;
      ld_first  <= 1'b0;
    end else begin
      ld_state  <= ld_next;
      cmp_state <= cmp_next;
      ld_first  <= (ld_next == L_FETCH) && (ld_state != L_FETCH);
    end
  end

  // Loader next state.
  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      L_IDLE:  if (start_accept) ld_next = L_FETCH;
      L_FETCH: if (i_win_done)   ld_next = L_FULL;
      // The window is consumed and, if pixels remain, the next fetch is launched on the
      // same o_cim_start edge, so FULL goes straight to FETCH without an idle cycle.
      L_FULL:  if (o_cim_start)  ld_next = ld_last ? L_IDLE : L_FETCH;
      default: ld_next = L_IDLE;
    endcase
  end

  // Compute next state.
  always_comb begin
    cmp_next = cmp_state;
    case (cmp_state)
      C_IDLE:      if (start_accept)                 cmp_next = C_WAIT_WIN;
      C_WAIT_WIN:  if (win_valid)                    cmp_next = C_MVM;
      C_MVM:       if (i_cim_done)                   cmp_next = C_WAIT_FUNC;
      C_WAIT_FUNC: if (i_func_ready && i_next_ready) cmp_next = C_DRAIN;
      C_DRAIN:     if (i_func_done)                  cmp_next = out_last ? C_IDLE : C_WAIT_WIN;
      default:                                       cmp_next = C_IDLE;
    endcase
  end

  // Handshake pulses and status decoded from current state and responder inputs.
  always_comb begin
    o_ready      = (cmp_state == C_IDLE) && (ld_state == L_IDLE);
    start_accept = i_start && o_ready;
    o_win_start  = (ld_state == L_FETCH) && ld_first;
    o_cim_start  = (cmp_state == C_WAIT_WIN) && win_valid;
    o_func_start = (cmp_state == C_WAIT_FUNC) && i_func_ready && i_next_ready;
    out_inc      = (cmp_state == C_DRAIN) && i_func_done;
    o_done       = out_inc && out_last;
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: event-level reference model checked every cycle, plus
// directed frames for zero-latency order, overlap, backpressure, ignored inputs and reset.
module tb_conv_layer_sched;

  localparam int IMG  = 4;
  localparam int KER  = 3;
  localparam int OD   = IMG - KER + 1;
  localparam int NPIX = OD * OD;
  localparam int CW   = ($clog2(OD) < 1) ? 1 : $clog2(OD);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic i_win_done = 1'b0;
  logic i_cim_done = 1'b0;
  logic i_func_ready = 1'b0;
  logic i_next_ready = 1'b0;
  logic i_func_done = 1'b0;
  logic o_ready, o_done, o_win_start, o_cim_start, o_func_start;
  logic [CW-1:0] o_win_row, o_win_col, o_out_row, o_out_col;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  conv_layer_sched #(
    .IMG_DIM    (IMG),
    .KERNEL_DIM (KER)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .o_ready      (o_ready),
    .o_done       (o_done),
    .o_win_start  (o_win_start),
    .o_win_row    (o_win_row),
    .o_win_col    (o_win_col),
    .i_win_done   (i_win_done),
    .o_cim_start  (o_cim_start),
    .i_cim_done   (i_cim_done),
    .o_func_start (o_func_start),
    .i_func_ready (i_func_ready),
    .i_next_ready (i_next_ready),
    .i_func_done  (i_func_done),
    .o_out_row    (o_out_row),
    .o_out_col    (o_out_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- responders ----------------
  bit rnd_mode = 1'b0;
  int bp_req = 0;
  int bp_seen = 0;
  int bp_left = 0;
  bit bp_wait = 1'b0;
  int bp_c0 = 0;
  int win_cnt = 0, cim_cnt = 0, fun_cnt = 0;

  always begin
    @(negedge clk);
    if (rst) begin
      win_cnt = 0; cim_cnt = 0; fun_cnt = 0; bp_left = 0; bp_wait = 1'b0;
    end else begin
      if (o_win_start)  win_cnt = rnd_mode ? int'($urandom_range(1, 6)) : 1;
      if (o_cim_start)  cim_cnt = rnd_mode ? int'($urandom_range(1, 5)) : 1;
      if (o_func_start) begin
        fun_cnt = rnd_mode ? int'($urandom_range(1, 4)) : 1;
        bp_wait = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    i_win_done = 1'b0;
    if (win_cnt > 0) begin win_cnt--; if (win_cnt == 0) i_win_done = 1'b1; end
    i_cim_done = 1'b0;
    if (cim_cnt > 0) begin
      cim_cnt--;
      if (cim_cnt == 0) begin
        i_cim_done = 1'b1;
        if (bp_req != bp_seen) begin
          bp_seen = bp_req; bp_left = 21; bp_wait = 1'b1; bp_c0 = cyc;
        end
      end
    end
    if (bp_left == 10) i_cim_done = 1'b1;   // stray pulse while waiting for the post-process block
    i_func_done = 1'b0;
    if (fun_cnt > 0) begin fun_cnt--; if (fun_cnt == 0) i_func_done = 1'b1; end
    if (bp_left > 0) begin
      i_next_ready = 1'b0; i_func_ready = 1'b1; bp_left--;
    end else if (bp_wait || !rnd_mode) begin
      i_next_ready = 1'b1; i_func_ready = 1'b1;
    end else begin
      i_next_ready = ($urandom_range(0, 3) != 0);
      i_func_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit m_active = 0, m_trig = 0, m_fetching = 0;
  int m_wd = 0, m_cims = 0, m_cd = 0, m_fs = 0, m_fd = 0;
  bit e_ready, e_win, e_cim, e_func, e_done, acc, wd_ok, cd_ok, fd_ok;
  int cim_log[$];
  int nwin = 0, win1 = -1, t_win2 = -1, t_fd1 = -1, t_cim2 = -1, t_fs1 = -1, nfs = 0, ndone = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_active = 0; m_trig = 0; m_fetching = 0;
      m_wd = 0; m_cims = 0; m_cd = 0; m_fs = 0; m_fd = 0;
    end else begin
      e_ready = !m_active;
      e_win   = m_trig;
      e_cim   = m_active && (m_wd > m_cims) && (m_fd == m_cims) && (m_cims < NPIX);
      e_func  = (m_cd > m_fs) && i_func_ready && i_next_ready;
      e_done  = i_func_done && (m_fs > m_fd) && (m_fd + 1 == NPIX);

      chk("o_ready", o_ready, e_ready);
      chk("o_win_start", o_win_start, e_win);
      chk("o_cim_start", o_cim_start, e_cim);
      chk("o_func_start", o_func_start, e_func);
      chk("o_done", o_done, e_done);
      chk("o_win_row", int'(o_win_row), (m_cims % NPIX) / OD);
      chk("o_win_col", int'(o_win_col), (m_cims % NPIX) % OD);
      chk("o_out_row", int'(o_out_row), (m_fd % NPIX) / OD);
      chk("o_out_col", int'(o_out_col), (m_fd % NPIX) % OD);

      acc   = i_start && e_ready;
      wd_ok = i_win_done && (m_fetching || e_win);
      cd_ok = i_cim_done && (m_cims > m_cd);
      fd_ok = i_func_done && (m_fs > m_fd);

      // per-frame observation log for the directed checks
      if (acc) begin
        cim_log.delete();
        nwin = 0; win1 = -1; t_win2 = -1; t_fd1 = -1; t_cim2 = -1; t_fs1 = -1; nfs = 0; ndone = 0;
      end
      if (o_cim_start) begin
        if (cim_log.size() == 1) t_cim2 = cyc;
        cim_log.push_back(int'(o_out_row) * OD + int'(o_out_col));
      end
      if (o_win_start) begin
        nwin++;
        if (nwin == 1) win1 = int'(o_win_row) * OD + int'(o_win_col);
        if (nwin == 2) t_win2 = cyc;
      end
      if (o_func_start) begin
        if (nfs == 0) t_fs1 = cyc;
        nfs++;
      end
      if (fd_ok && t_fd1 < 0) t_fd1 = cyc;
      if (o_done) ndone++;

      m_trig = acc || (e_cim && (m_cims + 1 < NPIX));
      if (e_win) m_fetching = 1;
      if (wd_ok) begin m_fetching = 0; m_wd++; end
      if (cd_ok) m_cd++;
      if (fd_ok) m_fd++;
      if (e_cim) m_cims++;
      if (e_func) m_fs++;
      if (e_done) begin
        m_active = 0; m_wd = 0; m_cims = 0; m_cd = 0; m_fs = 0; m_fd = 0;
      end
      if (acc) m_active = 1;
    end
  end

  // ---------------- directed sequence ----------------
  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (o_done !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (k >= lim) chk("done_timeout", 0, 1);
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_cim_count"}, cim_log.size(), NPIX);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("%s_cim_pix%0d", tag, i), (i < cim_log.size()) ? cim_log[i] : -1, i);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_pulses", {o_done, o_win_start, o_cim_start, o_func_start}, 0);
    chk("rst_coords", {o_win_row, o_win_col, o_out_row, o_out_col}, 0);

    // zero-latency frame
    pulse_start();
    wait_done(500);
    @(negedge clk);
    chk("A_ready_after", o_ready, 1);
    check_order("A");
    chk("A_func_starts", nfs, 4);
    chk("A_dones", ndone, 1);
    chk("A_overlap_win2_before_fd1", int'(t_win2 >= 0 && t_win2 < t_fd1), 1);
    chk("A_cim2_after_fd1", int'(t_cim2 >= t_fd1 + 1), 1);

    // random frame with backpressure, stray cim_done and a mid-frame i_start
    rnd_mode = 1'b1;
    bp_req++;
    pulse_start();
    repeat (6) @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_done(2000);
    @(negedge clk);
    chk("B_ready_after", o_ready, 1);
    check_order("B");
    chk("B_func_starts", nfs, 4);
    chk("B_dones", ndone, 1);
    chk("B_bp_release_cycle", t_fs1 - bp_c0, 21);

    // reset while pixel (0,1) is in MVM
    rnd_mode = 1'b0;
    pulse_start();
    begin
      int k = 0;
      while (!(o_cim_start === 1'b1 && o_out_row == 0 && int'(o_out_col) == 1) && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (k >= 200) chk("C_reach_pix1_timeout", 0, 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("C_no_done", ndone, 0);
    chk("C_ready_after_rst", o_ready, 1);

    rnd_mode = 1'b1;
    pulse_start();
    wait_done(2000);
    @(negedge clk);
    chk("D_first_window", win1, 0);
    chk("D_dones", ndone, 1);
    check_order("D");

    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulse_start();
      wait_done(2000);
      @(negedge clk);
      chk($sformatf("R%0d_dones", f), ndone, 1);
      chk($sformatf("R%0d_func_starts", f), nfs, 4);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
